// File: rtl/lock_responder_pkg.sv
// Shared definitions for the accelerator lock responder.
// Holds command/ack field positions, protocol codes and the responder FSM state type.
package lock_responder_pkg;

  // Command word fields
  localparam int unsigned CMD_CODE_L   = 0;
  localparam int unsigned CMD_CODE_H   = 7;
  localparam int unsigned LOCK_ID_L    = 8;
  localparam int unsigned LOCK_ID_H    = 15;
  localparam int unsigned LOCK_ID_BITS = 8;

  // Ack word fields
  localparam int unsigned ACK_CODE_L   = 0;
  localparam int unsigned ACK_CODE_H   = 7;
  localparam int unsigned ACK_LOCKID_L = 8;
  localparam int unsigned ACK_LOCKID_H = 15;

  localparam logic [7:0] CMD_LOCK_CODE   = 8'h04;
  localparam logic [7:0] CMD_UNLOCK_CODE = 8'h06;
  localparam logic [7:0] ACK_OK_CODE     = 8'h01;
  localparam logic [7:0] ACK_REJECT_CODE = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    SEND_ACK,
    DRAIN
  } lock_resp_state_t;

endpackage

// File: rtl/lock_responder_if.sv
// Command-in / ack-out stream pair of the lock responder.
//   cmd_in_*  : command stream from the manager interconnect (tdata, tvalid, tready, tid, tlast)
//   ack_out_* : ack stream to the accelerator return interconnect (tdata, tvalid, tready, tdest)
// master: the requester side (drives commands, accepts acks); slave: the responder.
interface lock_responder_if #(
  parameter int unsigned ACC_BITS = 4
);
  logic [63:0]         cmd_in_tdata;
  logic                cmd_in_tvalid;
  logic                cmd_in_tready;
  logic [ACC_BITS-1:0] cmd_in_tid;
  logic                cmd_in_tlast;

  logic [63:0]         ack_out_tdata;
  logic                ack_out_tvalid;
  logic                ack_out_tready;
  logic [ACC_BITS-1:0] ack_out_tdest;

  modport master (
    output cmd_in_tdata, cmd_in_tvalid, cmd_in_tid, cmd_in_tlast, ack_out_tready,
    input  cmd_in_tready, ack_out_tdata, ack_out_tvalid, ack_out_tdest
  );

  modport slave (
    input  cmd_in_tdata, cmd_in_tvalid, cmd_in_tid, cmd_in_tlast, ack_out_tready,
    output cmd_in_tready, ack_out_tdata, ack_out_tvalid, ack_out_tdest
  );
endinterface

// File: rtl/lock_responder_lock_table.sv
// Lock table: NUM_LOCKS entries of {locked, owner}, plus the count of held locks.
//   clk, rstn      : clock, async active-low reset
//   i_id           : lock ID used by both the read port and the write port
//   o_in_range     : i_id addresses an implemented lock
//   o_locked/owner : combinational read of the addressed entry (0 when out of range)
//   i_set/i_clr    : grant to i_owner / free the addressed entry
//   o_locks_held   : number of locked entries
module lock_responder_lock_table
  import lock_responder_pkg::*;
#(
  parameter int unsigned ACC_BITS  = 4,
  parameter int unsigned NUM_LOCKS = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [LOCK_ID_BITS-1:0] i_id,
  output logic                    o_in_range,
  output logic                    o_locked,
  output logic [ACC_BITS-1:0]     o_owner,
  input  logic                    i_set,
  input  logic                    i_clr,
  input  logic [ACC_BITS-1:0]     i_owner,
  output logic [8:0]              o_locks_held
);

  logic [NUM_LOCKS-1:0] r_locked;
  logic [ACC_BITS-1:0]  r_owner [NUM_LOCKS];
  logic [8:0]           r_count;

  // 9-bit compare so NUM_LOCKS=256 still works; IDs never alias.
  assign o_in_range   = {1'b0, i_id} < 9'(NUM_LOCKS);
  assign o_locks_held = r_count;

  always_comb begin
    o_locked = 1'b0;
    o_owner  = '0;
    for (int i = 0; i < NUM_LOCKS; i++) begin
      if (i_id == LOCK_ID_BITS'(i)) begin
        o_locked = r_locked[i];
        o_owner  = r_owner[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_locked <= '0;
      r_count  <= '0;
      for (int i = 0; i < NUM_LOCKS; i++) r_owner[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LOCKS; i++) begin
        if (i_id == LOCK_ID_BITS'(i)) begin
          if (i_set) begin
            r_locked[i] <= 1'b1;
            r_owner[i]  <= i_owner;
          end else if (i_clr) begin
            r_locked[i] <= 1'b0;
            r_owner[i]  <= '0;
          end
        end
      end
      // Set/clear only fire on real state changes, so the count stays in 0..NUM_LOCKS.
      if (i_set) begin
        r_count <= r_count + 9'd1;
      end else if (i_clr) begin
        r_count <= r_count - 9'd1;
      end
    end
  end

endmodule

// File: rtl/lock_responder.sv
// Responder end of the accelerator lock protocol: decodes LOCK/UNLOCK commands,
// updates the lock table and returns ACK_OK/ACK_REJECT for lock requests.
//   clk, rstn  : clock, async active-low reset
//   bus        : command-in / ack-out streams (slave view)
//   locks_held : number of currently locked entries
//   err_sticky : protocol error seen since last clear
//   err_clr    : one-cycle pulse clearing err_sticky (a same-cycle error wins)
module lock_responder
  import lock_responder_pkg::*;
#(
  parameter int unsigned ACC_BITS  = 4,
  parameter int unsigned NUM_LOCKS = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  lock_responder_if.slave        bus,
  output logic [8:0]             locks_held,
  output logic                   err_sticky,
  input  logic                   err_clr
);

  lock_resp_state_t        r_state;
  logic                    r_tready;
  logic [7:0]              r_code;
  logic [LOCK_ID_BITS-1:0] r_id;
  logic [ACC_BITS-1:0]     r_tid;
  logic                    r_ack_valid;
  logic [63:0]             r_ack_data;
  logic [ACC_BITS-1:0]     r_ack_dest;
  logic                    r_err;

  logic                    w_in_range;
  logic                    w_locked;
  logic [ACC_BITS-1:0]     w_owner;
  logic                    w_set;
  logic                    w_clr;
  logic                    w_unused_tdata;

  assign w_unused_tdata = ^bus.cmd_in_tdata[63:16];

  // Table writes happen at the end of CHECK, so locks_held moves one cycle later.
  assign w_set = (r_state == CHECK) && (r_code == CMD_LOCK_CODE) && w_in_range && !w_locked;
  assign w_clr = (r_state == CHECK) && (r_code == CMD_UNLOCK_CODE) && w_in_range &&
                 w_locked && (w_owner == r_tid);

  lock_responder_lock_table #(
    .ACC_BITS  (ACC_BITS),
    .NUM_LOCKS (NUM_LOCKS)
  ) u_table (
    .clk          (clk),
    .rstn         (rstn),
    .i_id         (r_id),
    .o_in_range   (w_in_range),
    .o_locked     (w_locked),
    .o_owner      (w_owner),
    .i_set        (w_set),
    .i_clr        (w_clr),
    .i_owner      (r_tid),
    .o_locks_held (locks_held)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_tready    <= 1'b0;
      r_code      <= '0;
      r_id        <= '0;
      r_tid       <= '0;
      r_ack_valid <= 1'b0;
      r_ack_data  <= '0;
      r_ack_dest  <= '0;
      r_err       <= 1'b0;
    end else begin
      // Error sets below are later NBAs and therefore override this clear.
      if (err_clr) r_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_tready <= 1'b1;
          if (r_tready && bus.cmd_in_tvalid) begin
            r_code <= bus.cmd_in_tdata[CMD_CODE_H:CMD_CODE_L];
            r_id   <= bus.cmd_in_tdata[LOCK_ID_H:LOCK_ID_L];
            r_tid  <= bus.cmd_in_tid;
            if (!bus.cmd_in_tlast) begin
              r_err   <= 1'b1;
              r_state <= DRAIN;
            end else begin
              r_tready <= 1'b0;
              r_state  <= CHECK;
            end
          end
        end
        DRAIN: begin
          if (r_tready && bus.cmd_in_tvalid && bus.cmd_in_tlast) r_state <= IDLE;
        end
        CHECK: begin
          r_state  <= IDLE;
          r_tready <= 1'b1;
          if (r_code == CMD_LOCK_CODE) begin
            r_state     <= SEND_ACK;
            r_tready    <= 1'b0;
            r_ack_valid <= 1'b1;
            r_ack_dest  <= r_tid;
            r_ack_data  <= '0;
            r_ack_data[ACK_LOCKID_H:ACK_LOCKID_L] <= r_id;
            r_ack_data[ACK_CODE_H:ACK_CODE_L]     <= w_set ? ACK_OK_CODE : ACK_REJECT_CODE;
            if (!w_in_range) r_err <= 1'b1;
          end else if (r_code == CMD_UNLOCK_CODE) begin
            if (!w_clr) r_err <= 1'b1;
          end else begin
            r_err <= 1'b1;
          end
        end
        SEND_ACK: begin
          if (bus.ack_out_tready) begin
            r_ack_valid <= 1'b0;
            r_tready    <= 1'b1;
            r_state     <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.cmd_in_tready  = r_tready;
  assign bus.ack_out_tvalid = r_ack_valid;
  assign bus.ack_out_tdata  = r_ack_data;
  assign bus.ack_out_tdest  = r_ack_dest;
  assign err_sticky         = r_err;

endmodule

// File: tb/tb_lock_responder.sv
// Randomised scoreboard bench for lock_responder with a lock-table reference model.
module tb_lock_responder;
  localparam int unsigned ACC_BITS  = 4;
  localparam int unsigned NUM_LOCKS = 16;
  localparam logic [7:0]  LK = 8'h04;
  localparam logic [7:0]  UL = 8'h06;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       err_clr = 1'b0;
  logic [8:0] locks_held;
  logic       err_sticky;

  lock_responder_if #(.ACC_BITS(ACC_BITS)) bus ();

  lock_responder #(
    .ACC_BITS  (ACC_BITS),
    .NUM_LOCKS (NUM_LOCKS)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .locks_held (locks_held),
    .err_sticky (err_sticky),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc = 0;
  int rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  dest;
    int          acc;
  } exp_t;
  exp_t sb[$];

  // Reference model: which locks are held and by whom, plus error/drain flags.
  bit m_locked[256];
  int m_owner[256];
  bit m_err;
  bit m_drain;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(string name, string info);
    total++;
    bad++;
    $display("FAIL %s: %s (t=%0t)", name, info, $time);
  endtask

  function automatic int held_count();
    int n = 0;
    for (int i = 0; i < 256; i++) n += int'(m_locked[i]);
    return n;
  endfunction

  function automatic logic [63:0] mk(logic [7:0] code, logic [7:0] id);
    return {48'h0, id, code};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      m_locked[i] = 1'b0;
      m_owner[i]  = 0;
    end
    m_err   = 1'b0;
    m_drain = 1'b0;
    sb.delete();
  endtask

  task automatic model_beat(logic [63:0] d, logic [3:0] tid, bit last, int acc);
    logic [7:0] code;
    logic [7:0] id;
    exp_t e;
    code = d[7:0];
    id   = d[15:8];
    if (m_drain) begin
      if (last) m_drain = 1'b0;
      return;
    end
    if (!last) begin
      m_err   = 1'b1;
      m_drain = 1'b1;
      return;
    end
    if (code == LK) begin
      e.dest = tid;
      e.acc  = acc;
      if (int'(id) >= NUM_LOCKS) begin
        m_err  = 1'b1;
        e.data = mk(8'h00, id);
      end else if (m_locked[id]) begin
        e.data = mk(8'h00, id);
      end else begin
        m_locked[id] = 1'b1;
        m_owner[id]  = int'(tid);
        e.data       = mk(8'h01, id);
      end
      sb.push_back(e);
    end else if (code == UL) begin
      if (int'(id) < NUM_LOCKS && m_locked[id] && m_owner[id] == int'(tid)) m_locked[id] = 1'b0;
      else m_err = 1'b1;
    end else begin
      m_err = 1'b1;
    end
  endtask

  // Ack ready driver
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.ack_out_tready = 1'b0;
      1:       bus.ack_out_tready = 1'b1;
      default: bus.ack_out_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: ack stability, ordering, content and latency.
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [63:0] pd = '0;
  logic [3:0]  pdst = '0;
  int          rise_cyc = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      if (pv && !pr) begin
        chk("ack_hold_valid", bus.ack_out_tvalid, 1'b1);
        chk("ack_hold_data", bus.ack_out_tdata, pd);
        chk("ack_hold_dest", bus.ack_out_tdest, pdst);
      end
      if (bus.ack_out_tvalid && !pv) rise_cyc = cyc;
      if (bus.ack_out_tvalid && bus.ack_out_tready) begin
        if (sb.size() == 0) begin
          fail("unexpected_ack", $sformatf("tdata=0x%0h with no ack expected", bus.ack_out_tdata));
        end else begin
          e = sb.pop_front();
          chk("ack_data", bus.ack_out_tdata, e.data);
          chk("ack_dest", bus.ack_out_tdest, e.dest);
          chk("ack_latency", rise_cyc - e.acc, 2);
        end
      end
      pv   = bus.ack_out_tvalid;
      pr   = bus.ack_out_tready;
      pd   = bus.ack_out_tdata;
      pdst = bus.ack_out_tdest;
    end
  end

  task automatic send_beat(logic [63:0] d, logic [3:0] tid, bit last, bit clr);
    int n = 0;
    @(negedge clk);
    bus.cmd_in_tdata  = d;
    bus.cmd_in_tid    = tid;
    bus.cmd_in_tlast  = last;
    bus.cmd_in_tvalid = 1'b1;
    while (bus.cmd_in_tready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      fail("cmd_accept_timeout", $sformatf("tdata=0x%0h never accepted", d));
      bus.cmd_in_tvalid = 1'b0;
      return;
    end
    if (clr) begin
      err_clr = 1'b1;
      m_err   = 1'b0;
    end
    last_acc = cyc;
    model_beat(d, tid, last, cyc);
    @(posedge clk);
    #1;
    bus.cmd_in_tvalid = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      fail("ack_timeout", $sformatf("%0d acks outstanding", sb.size()));
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_status(string tag);
    wait_idle();
    chk({tag, "_locks_held"}, locks_held, held_count());
    chk({tag, "_err"}, err_sticky, m_err);
    chk({tag, "_cmd_tready"}, bus.cmd_in_tready, 1'b1);
  endtask

  task automatic clear_err();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_err   = 1'b0;
    chk("err_clr_pulse", err_sticky, 1'b0);
  endtask

  task automatic wait_ack_valid(string tag);
    int n = 0;
    while (bus.ack_out_tvalid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) fail({tag, "_valid_timeout"}, "ack_out_tvalid never rose");
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1;
    bus.cmd_in_tdata   = '0;
    bus.cmd_in_tvalid  = 1'b0;
    bus.cmd_in_tid     = '0;
    bus.cmd_in_tlast   = 1'b0;
    bus.ack_out_tready = 1'b1;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_tready", bus.cmd_in_tready, 1'b0);
    chk("rst_ack_valid", bus.ack_out_tvalid, 1'b0);
    chk("rst_ack_data", bus.ack_out_tdata, 64'h0);
    chk("rst_ack_dest", bus.ack_out_tdest, 4'h0);
    chk("rst_locks_held", locks_held, 9'd0);
    chk("rst_err", err_sticky, 1'b0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rel_cmd_tready", bus.cmd_in_tready, 1'b1);

    // Grant, reject, wrong-owner unlock, owner unlock, regrant
    send_beat(mk(LK, 8'd3), 4'd2, 1'b1, 1'b0);
    check_status("lock3_acc2");
    send_beat(mk(LK, 8'd3), 4'd5, 1'b1, 1'b0);
    check_status("lock3_acc5_reject");
    send_beat(mk(UL, 8'd3), 4'd5, 1'b1, 1'b0);
    check_status("unlock3_wrong_owner");
    clear_err();
    send_beat(mk(UL, 8'd3), 4'd2, 1'b1, 1'b0);
    check_status("unlock3_owner");
    send_beat(mk(LK, 8'd3), 4'd5, 1'b1, 1'b0);
    check_status("relock3_acc5");

    // Out-of-range lock, clear, then clear coincident with a new error
    send_beat(mk(LK, 8'd20), 4'd1, 1'b1, 1'b0);
    check_status("lock20_oor");
    clear_err();
    send_beat(mk(LK, 8'd1), 4'd0, 1'b0, 1'b1);
    send_beat(mk(8'h00, 8'd0), 4'd0, 1'b1, 1'b0);
    check_status("clr_vs_set");
    clear_err();

    // Back-pressure: ack held for 10 cycles, then released
    rdy_mode = 0;
    send_beat(mk(LK, 8'd5), 4'd3, 1'b1, 1'b0);
    wait_ack_valid("stall");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_cmd_tready", bus.cmd_in_tready, 1'b0);
    end
    rdy_mode = 1;
    @(negedge clk);
    @(negedge clk);
    chk("post_hs_cmd_tready", bus.cmd_in_tready, 1'b1);
    chk("post_hs_ack_valid", bus.ack_out_tvalid, 1'b0);
    check_status("stall");

    // Three-beat command is drained without an ack
    send_beat(mk(LK, 8'd9), 4'd4, 1'b0, 1'b0);
    send_beat(64'hDEAD_BEEF_0000_0A04, 4'd4, 1'b0, 1'b0);
    send_beat(mk(LK, 8'd9), 4'd4, 1'b1, 1'b0);
    check_status("multibeat");
    clear_err();
    send_beat(mk(LK, 8'd9), 4'd4, 1'b1, 1'b0);
    check_status("after_drain");

    // Unlock throughput: one per two cycles
    send_beat(mk(LK, 8'd10), 4'd6, 1'b1, 1'b0);
    send_beat(mk(LK, 8'd11), 4'd6, 1'b1, 1'b0);
    check_status("pre_unlock_pair");
    send_beat(mk(UL, 8'd10), 4'd6, 1'b1, 1'b0);
    a1 = last_acc;
    send_beat(mk(UL, 8'd11), 4'd6, 1'b1, 1'b0);
    chk("unlock_throughput", last_acc - a1, 2);
    check_status("unlock_pair");

    // Randomised traffic with random ack back-pressure
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      logic [7:0]  code;
      logic [7:0]  id;
      logic [3:0]  tid;
      logic [47:0] hi;
      bit          last;
      bit          clr;
      int          r;
      r    = $urandom_range(0, 99);
      code = (r < 45) ? LK : (r < 85) ? UL : 8'($urandom());
      id   = ($urandom_range(0, 99) < 85) ? 8'($urandom_range(0, NUM_LOCKS - 1))
                                          : 8'($urandom_range(0, 255));
      tid  = 4'($urandom_range(0, 3));
      hi   = {16'($urandom()), 32'($urandom())};
      last = ($urandom_range(0, 19) != 0);
      clr  = ($urandom_range(0, 9) == 0);
      send_beat({hi, id, code}, tid, last, clr);
      if (!last) begin
        int extra;
        extra = $urandom_range(0, 2);
        for (int k = 0; k < extra; k++) send_beat({hi, 8'($urandom()), code}, tid, 1'b0, 1'b0);
        send_beat({hi, id, code}, tid, 1'b1, 1'b0);
      end
      if (i % 10 == 9) check_status("random");
    end
    rdy_mode = 1;
    check_status("random_end");

    // Reset while an ack is pending
    rdy_mode = 0;
    send_beat(mk(LK, 8'd7), 4'd1, 1'b1, 1'b0);
    wait_ack_valid("midrst");
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_ack_valid", bus.ack_out_tvalid, 1'b0);
    chk("midrst_locks_held", locks_held, 9'd0);
    chk("midrst_cmd_tready", bus.cmd_in_tready, 1'b0);
    chk("midrst_err", err_sticky, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    #2;
    rstn = 1'b1;
    rdy_mode = 1;
    check_status("after_midrst");
    send_beat(mk(LK, 8'd7), 4'd9, 1'b1, 1'b0);
    check_status("relock7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lock_responder.md
Name: lock_responder

Overview:
- Responder end of the accelerator lock protocol.
- Accelerators send CMD_LOCK (0x04) and CMD_UNLOCK (0x06) command words. This block holds the lock table and returns ACK_OK or ACK_REJECT to the issuing accelerator.
- Sits behind the HWR_LOCK_ID input port of the manager's command interconnect. Its ack stream feeds the accelerator return interconnect.

Parameters:
- ACC_BITS, 4, width of the accelerator ID carried on tid/tdest.
- NUM_LOCKS, 16, number of implemented locks; legal range 1..256.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- cmd_in_tdata  in  64  command word
- cmd_in_tvalid  in  1  command valid
- cmd_in_tready  out  1  command ready
- cmd_in_tid  in  ACC_BITS  issuing accelerator ID
- cmd_in_tlast  in  1  last beat of command
- ack_out_tdata  out  64  ack word
- ack_out_tvalid  out  1  ack valid
- ack_out_tready  in  1  ack ready
- ack_out_tdest  out  ACC_BITS  destination accelerator ID
- locks_held  out  9  count of currently locked entries
- err_sticky  out  1  protocol error seen since last clear
- err_clr  in  1  single-cycle pulse; clears err_sticky

Behaviour:
- Reset (async on rstn low, released synchronously):
  - All table entries unlocked; owners 0.
  - cmd_in_tready=0, ack_out_tvalid=0, ack_out_tdata=0, ack_out_tdest=0, locks_held=0, err_sticky=0.
  - FSM goes to IDLE.
  - Reset mid-operation drops any pending ack and frees all locks.
- Command decode:
  - Code in tdata[7:0]; lock ID in tdata[15:8]. Remaining bits ignored.
  - A lock command is one beat with tlast=1.
- FSM states: IDLE, CHECK, SEND_ACK, DRAIN.
- IDLE:
  - cmd_in_tready=1. On tvalid&tready, register code, lock ID, tid and tlast.
  - tlast=0: set err_sticky, go to DRAIN.
  - Otherwise go to CHECK.
- DRAIN:
  - cmd_in_tready=1. Consume beats until a beat with tlast=1, then go to IDLE.
  - No ack is generated.
- CHECK (one cycle, cmd_in_tready=0):
  - LOCK, id < NUM_LOCKS, entry free: set locked and owner=tid; ack code 0x01 (ACK_OK); go to SEND_ACK.
  - LOCK, entry already locked (any owner, including the requester): ack 0x00 (ACK_REJECT); table unchanged; go to SEND_ACK.
  - LOCK, id >= NUM_LOCKS: ack 0x00; set err_sticky.
  - UNLOCK, entry locked and owner==tid: clear entry; no ack; go to IDLE.
  - UNLOCK, entry free, owner mismatch, or id out of range: table unchanged; set err_sticky; no ack; go to IDLE.
  - Any other code: set err_sticky; go to IDLE.
- SEND_ACK:
  - ack_out_tvalid=1.
  - ack_out_tdata: [7:0]=ack code, [15:8]=echoed lock ID, [63:16]=0.
  - ack_out_tdest = registered tid.
  - tdata, tdest and tvalid stay stable until ack_out_tready. Return to IDLE in the cycle after the handshake.
  - cmd_in_tready=0 throughout, so only one command is in flight.
- Latency:
  - Command accepted in cycle N gives ack_out_tvalid in cycle N+2.
  - Next command can be accepted in cycle N+3 when ack_out_tready=1 at N+2.
  - Unlock throughput: one per 2 cycles.
- locks_held: +1 on granted lock, -1 on valid unlock; updated in the cycle after CHECK. Cannot over- or underflow, because only state-changing operations count.
- err_sticky: set wins over a simultaneous err_clr.
- Lock ID is 8 bits. No wrap-around; out-of-range IDs are rejected, never aliased.

Decomposition:
- Shared package additions:
  - ACK_CODE_L=0, ACK_CODE_H=7, ACK_LOCKID_L=8, ACK_LOCKID_H=15.
  - lock_resp_state_t enum {IDLE, CHECK, SEND_ACK, DRAIN}.
  - Reuse the existing CMD_LOCK_CODE, CMD_UNLOCK_CODE, LOCK_ID_L/H, LOCK_ID_BITS, ACK_OK_CODE and ACK_REJECT_CODE.
- Sub-module lock_table:
  - NUM_LOCKS × {locked, owner[ACC_BITS]} flop array.
  - Combinational read port, single write port (set/clear).
  - Also owns the locks_held counter.

Test Plan:
- Lock id 3 from acc 2 (tdata=0x0304, tid=2, tlast=1) -> ack_out_tvalid at N+2, tdata=0x0301, tdest=2, locks_held=1.
- Then lock id 3 from acc 5 -> ack tdata=0x0300 (reject), tdest=5, locks_held stays 1. Unlock id 3 from acc 5 -> no ack, err_sticky=1, lock kept.
- Unlock id 3 from acc 2 (0x0306) -> no ack, locks_held=0. Lock id 3 from acc 5 -> 0x0301.
- Lock id 20 with NUM_LOCKS=16 -> ack 0x1400, err_sticky=1. err_clr pulse -> 0. err_clr coincident with a new error -> remains 1.
- Hold ack_out_tready=0 for 10 cycles after a lock -> ack_out_tdata/tdest/tvalid stable, cmd_in_tready=0. Release -> handshake, cmd_in_tready=1 next cycle.
- Three-beat command with tlast only on beat 3 -> all beats consumed, no ack, err_sticky=1. Assert rstn=0 during SEND_ACK -> ack_out_tvalid=0 immediately, locks_held=0.
